// File: rtl/adc_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | adc_pkg : shared types and constants for the ADC word aligner           |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package adc_pkg;

    localparam int          ADC_WORD_W        = 12;
    localparam logic [11:0] TRAIN_PATTERN_DEF = 12'hF80;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETTLE_WAIT = 3'd1,
        ST_SEARCH      = 3'd2,
        ST_CHECK       = 3'd3,
        ST_LOCKED      = 3'd4
    } align_state_t;

    // Offset 11 wraps back to 0; the caller flags the wrap as a failed sweep.
    function automatic logic [3:0] next_slip(input logic [3:0] s);
        return (s == 4'd11) ? 4'd0 : s + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_word_rotate.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | adc_word_rotate : selects a 12-bit window from two consecutive words    |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module adc_word_rotate
    import adc_pkg::*;
(
    input  logic [2*ADC_WORD_W-1:0] win_in,
    input  logic [3:0]              sel,
    output logic [ADC_WORD_W-1:0]   word_out
);

    logic [2*ADC_WORD_W-1:0] shifted;

    always_comb begin
        shifted  = win_in >> sel;
        word_out = shifted[ADC_WORD_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/adc_word_align.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | adc_word_align : training-pattern bit-slip search and word alignment    |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module adc_word_align
    import adc_pkg::*;
#(
    parameter logic [ADC_WORD_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
    parameter int                    LOCK_COUNT    = 16,
    parameter int                    SETTLE        = 4
) (
    input  logic                  adc_clk_x2,
    input  logic                  rst,
    input  logic [ADC_WORD_W-1:0] data_in,
    input  logic                  train_en,
    input  logic                  realign,
    output logic [ADC_WORD_W-1:0] data_out,
    output logic                  data_valid,
    output logic                  locked,
    output logic [3:0]            slip,
    output logic                  align_fail,
    output logic                  lock_lost
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_COUNT - 1);

    align_state_t            state_q, state_d;
    logic [ADC_WORD_W-1:0]   cur_w_q, cur_w_d;
    logic [ADC_WORD_W-1:0]   prev_w_q, prev_w_d;
    logic [ADC_WORD_W-1:0]   data_out_q, data_out_d;
    logic [3:0]              slip_q, slip_d;
    logic [3:0]              settle_cnt_q, settle_cnt_d;
    logic [7:0]              match_cnt_q, match_cnt_d;
    logic                    locked_q, locked_d;
    logic                    align_fail_q, align_fail_d;
    logic                    lock_lost_q, lock_lost_d;
    logic [ADC_WORD_W-1:0]   window_word;
    logic                    match;

    adc_word_rotate u_rotate (
        .win_in   ({prev_w_q, cur_w_q}),
        .sel      (slip_q),
        .word_out (window_word)
    );

    assign match = (window_word == TRAIN_PATTERN);

    always_comb begin
        state_d      = state_q;
        cur_w_d      = data_in;
        prev_w_d     = cur_w_q;
        data_out_d   = window_word;
        slip_d       = slip_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        locked_d     = locked_q;
        align_fail_d = align_fail_q;
        lock_lost_d  = lock_lost_q;

        if (realign) begin
            locked_d     = 1'b0;
            align_fail_d = 1'b0;
            lock_lost_d  = 1'b0;
            slip_d       = 4'd0;
            settle_cnt_d = 4'd0;
            match_cnt_d  = 8'd0;
            state_d      = train_en ? ST_SETTLE_WAIT : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (train_en) begin
                        slip_d       = 4'd0;
                        settle_cnt_d = 4'd0;
                        state_d      = ST_SETTLE_WAIT;
                    end
                end
                ST_SETTLE_WAIT: begin
                    if (!train_en) begin
                        state_d = ST_IDLE;
                    end else if (settle_cnt_q >= SETTLE_CNT) begin
                        state_d = ST_SEARCH;
                    end else if (settle_cnt_q != 4'hF) begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end
                ST_SEARCH, ST_CHECK: begin
                    if (!train_en) begin
                        state_d = ST_IDLE;
                    end else if (match) begin
                        if (state_q == ST_SEARCH) begin
                            match_cnt_d = 8'd1;
                            state_d     = ST_CHECK;
                        end else begin
                            if (match_cnt_q != 8'hFF)
                                match_cnt_d = match_cnt_q + 8'd1;
                            if (match_cnt_q >= LOCK_LAST) begin
                                locked_d = 1'b1;
                                state_d  = ST_LOCKED;
                            end
                        end
                    end else begin
                        // Any miss moves to the next offset and lets the link settle.
                        slip_d       = next_slip(slip_q);
                        if (slip_q == 4'd11)
                            align_fail_d = 1'b1;
                        settle_cnt_d = 4'd0;
                        match_cnt_d  = 8'd0;
                        state_d      = ST_SETTLE_WAIT;
                    end
                end
                ST_LOCKED: begin
                    // Without training data there is nothing to compare against.
                    if (train_en && !match) begin
                        lock_lost_d  = 1'b1;
                        locked_d     = 1'b0;
                        settle_cnt_d = 4'd0;
                        match_cnt_d  = 8'd0;
                        state_d      = ST_SETTLE_WAIT;
                    end
                end
                default: begin
                    locked_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge adc_clk_x2 or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_w_q      <= '0;
            prev_w_q     <= '0;
            data_out_q   <= '0;
            slip_q       <= 4'd0;
            settle_cnt_q <= 4'd0;
            match_cnt_q  <= 8'd0;
            locked_q     <= 1'b0;
            align_fail_q <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_w_q      <= cur_w_d;
            prev_w_q     <= prev_w_d;
            data_out_q   <= data_out_d;
            slip_q       <= slip_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            locked_q     <= locked_d;
            align_fail_q <= align_fail_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = locked_q;
    assign locked     = locked_q;
    assign slip       = slip_q;
    assign align_fail = align_fail_q;
    assign lock_lost  = lock_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_word_align.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_adc_word_align : directed self-checking bench for adc_word_align     |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_adc_word_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        train_en;
    logic        realign;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        data_valid;
    logic        locked;
    logic [3:0]  slip;
    logic        align_fail;
    logic        lock_lost;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    adc_word_align dut (
        .adc_clk_x2 (clk),
        .rst        (rst),
        .data_in    (data_in),
        .train_en   (train_en),
        .realign    (realign),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .slip       (slip),
        .align_fail (align_fail),
        .lock_lost  (lock_lost)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_lock(input int budget);
        for (int i = 0; i < budget && !locked; i++) tick(1);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_locked"}, 16'(locked), 16'h0);
        chk({tag, "_valid"}, 16'(data_valid), 16'h0);
        chk({tag, "_slip"}, 16'(slip), 16'h0);
        chk({tag, "_align_fail"}, 16'(align_fail), 16'h0);
        chk({tag, "_lock_lost"}, 16'(lock_lost), 16'h0);
    endtask

    logic [11:0] dh [0:19];
    logic [23:0] pair;
    logic [11:0] seen;

    initial begin
        rst = 1'b1; train_en = 1'b0; realign = 1'b0; data_in = 12'h000;
        #2;
        chk_cleared("reset");
        chk("reset_data_out", 16'(data_out), 16'h000);
        tick(2);
        rst = 1'b0;
        data_in = 12'hF80;
        tick(3);
        chk("idle_no_lock", 16'(locked), 16'h0);

        // Aligned stream: lock after SETTLE+16+2 = 22 edges
        train_en = 1'b1;
        tick(21);
        chk("aligned_not_yet_locked", 16'(locked), 16'h0);
        tick(1);
        chk("aligned_locked_at_22", 16'(locked), 16'h1);
        chk("aligned_valid", 16'(data_valid), 16'h1);
        chk("aligned_slip", 16'(slip), 16'h0);
        chk("aligned_data_out", 16'(data_out), 16'hF80);

        // F80 rotated left by 5 -> 01F; aligner must find slip 5
        data_in = 12'h01F;
        realign = 1'b1;
        tick(1);
        realign = 1'b0;
        chk("realign_drops_lock", 16'(locked), 16'h0);
        wait_lock(400);
        chk("rot5_locked", 16'(locked), 16'h1);
        chk("rot5_slip", 16'(slip), 16'h5);
        chk("rot5_lock_lost_clear", 16'(lock_lost), 16'h0);
        chk("rot5_align_fail_clear", 16'(align_fail), 16'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rot5_data_out", 16'(data_out), 16'hF80);
            tick(1);
        end

        // One corrupted word while locked and training
        data_in = 12'hFFF;
        tick(1);
        data_in = 12'h01F;
        chk("corrupt_still_locked", 16'(locked), 16'h1);
        tick(1);
        chk("corrupt_locked_drops", 16'(locked), 16'h0);
        chk("corrupt_valid_drops", 16'(data_valid), 16'h0);
        chk("corrupt_lock_lost", 16'(lock_lost), 16'h1);
        wait_lock(400);
        chk("relock_locked", 16'(locked), 16'h1);
        chk("relock_same_slip", 16'(slip), 16'h5);
        chk("relock_lock_lost_sticky", 16'(lock_lost), 16'h1);

        // Training off: random data, lock held, output = window(5) two edges later
        train_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            dh[i] = 12'($urandom);
            data_in = dh[i];
            tick(1);
            if (i >= 2) begin
                pair = {dh[i-2], dh[i-1]} >> 5;
                chk("notrain_data_out", 16'(data_out), 16'(pair[11:0]));
                chk("notrain_locked", 16'(locked), 16'h1);
            end
        end

        // Realign while locked with training off -> IDLE, flags cleared
        realign = 1'b1;
        tick(1);
        realign = 1'b0;
        chk_cleared("realign_locked");
        data_in = 12'h01F;
        train_en = 1'b1;
        tick(3);
        chk("restart_slip0", 16'(slip), 16'h0);
        tick(4);
        chk("restart_slip1", 16'(slip), 16'h1);

        // Constant zero: full sweep, align_fail on the 11->0 wrap
        data_in = 12'h000;
        realign = 1'b1;
        tick(1);
        realign = 1'b0;
        seen = 12'h000;
        for (int i = 0; i < 300 && !align_fail; i++) begin
            if (slip < 4'd12) seen[slip] = 1'b1;
            tick(1);
        end
        chk("sweep_align_fail", 16'(align_fail), 16'h1);
        chk("sweep_wrap_slip0", 16'(slip), 16'h0);
        chk("sweep_all_offsets", 16'(seen), 16'hFFF);
        chk("sweep_no_lock", 16'(locked), 16'h0);

        // Reset in CHECK discards progress
        data_in = 12'hF80;
        realign = 1'b1;
        tick(1);
        realign = 1'b0;
        chk("realign_clears_fail", 16'(align_fail), 16'h0);
        tick(10);
        #2 rst = 1'b1;
        #1;
        chk_cleared("rst_in_check");
        chk("rst_in_check_data_out", 16'(data_out), 16'h000);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(15);
        chk("post_rst_not_locked", 16'(locked), 16'h0);
        chk("post_rst_slip0", 16'(slip), 16'h0);
        tick(7);
        chk("post_rst_locked_22", 16'(locked), 16'h1);
        chk("post_rst_lock_slip", 16'(slip), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
